// File: rtl/paint_write_scheduler.sv
// Write sequencer for the pixel frame store: buffers paint requests, runs clear sweeps,
// and issues every store write only while the VGA raster is blanked.
module paint_write_scheduler #(
    parameter int XW          = 8,
    parameter int YW          = 8,
    parameter int CW          = 3,
    parameter int DEPTH       = 4,
    parameter int XMAX        = 159,
    parameter int YMAX        = 119,
    parameter int CLEAR_COLOR = 0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [XW-1:0] req_x,
    input  logic [YW-1:0] req_y,
    input  logic [CW-1:0] req_color,
    input  logic          req_brush,
    input  logic          clear_req,
    input  logic          blank_b,
    output logic          wr_en,
    output logic [XW-1:0] wr_x,
    output logic [YW-1:0] wr_y,
    output logic [CW-1:0] wr_color,
    output logic          busy,
    output logic          err_oob
);

    localparam int AW = $clog2(DEPTH);
    localparam int EW = XW + YW + CW;

    localparam logic [XW-1:0] XLAST = XW'(XMAX);
    localparam logic [YW-1:0] YLAST = YW'(YMAX);
    localparam logic [CW-1:0] CLR   = CW'(CLEAR_COLOR);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DRAIN = 2'd1;
    localparam logic [1:0] S_CLEAR = 2'd2;

    logic [1:0]    r_state;
    logic [EW-1:0] r_mem [DEPTH];
    logic [AW:0]   r_wr_ptr;
    logic [AW:0]   r_rd_ptr;
    logic [XW-1:0] r_cx;
    logic [YW-1:0] r_cy;
    logic          r_wr_en;
    logic [XW-1:0] r_wr_x;
    logic [YW-1:0] r_wr_y;
    logic [CW-1:0] r_wr_color;
    logic          r_err_oob;

    logic          w_empty;
    logic          w_full;
    logic          w_push;
    logic          w_pop;
    logic          w_clr_issue;
    logic          w_clr_last;
    logic          w_will_empty;
    logic [EW-1:0] w_head;
    logic [XW-1:0] w_hx;
    logic [YW-1:0] w_hy;
    logic [CW-1:0] w_hc;
    logic          w_oob;
    logic [AW:0]   w_wr_ptr_nxt;
    logic [AW:0]   w_rd_ptr_nxt;

    // Extra pointer bit distinguishes full from empty when the index bits match.
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

    assign req_ready   = !w_full && (r_state != S_CLEAR) && !clear_req;
    assign w_push      = req_valid && req_ready;
    assign w_pop       = !blank_b && !w_empty && (r_state != S_CLEAR) && !clear_req;
    assign w_clr_issue = !blank_b && (r_state == S_CLEAR) && !clear_req;
    assign w_clr_last  = (r_cx == XLAST) && (r_cy == YLAST);

    assign w_head = r_mem[r_rd_ptr[AW-1:0]];
    assign w_hx   = w_head[EW-1 -: XW];
    assign w_hy   = w_head[CW +: YW];
    assign w_hc   = w_head[CW-1:0];
    assign w_oob  = (w_hx > XLAST) || (w_hy > YLAST);

    assign w_wr_ptr_nxt = r_wr_ptr + (AW+1)'(w_push);
    assign w_rd_ptr_nxt = r_rd_ptr + (AW+1)'(w_pop);
    assign w_will_empty = (w_wr_ptr_nxt == w_rd_ptr_nxt);

    // NOTE: the FIFO storage has no reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= {req_x, req_y, req_brush ? req_color : CLR};
        end
    end

    // NOTE: every sequential block uses non-blocking assignments so all registers update
    // from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cx     <= '0;
            r_cy     <= '0;
        end else if (clear_req) begin
            r_state  <= S_CLEAR;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cx     <= '0;
            r_cy     <= '0;
        end else begin
            r_wr_ptr <= w_wr_ptr_nxt;
            r_rd_ptr <= w_rd_ptr_nxt;
            if (r_state == S_CLEAR) begin
                if (w_clr_issue) begin
                    if (w_clr_last) begin
                        r_state <= S_IDLE;
                    end
                    if (r_cx == XLAST) begin
                        r_cx <= '0;
                        r_cy <= r_cy + YW'(1);
                    end else begin
                        r_cx <= r_cx + XW'(1);
                    end
                end
            end else begin
                r_state <= w_will_empty ? S_IDLE : S_DRAIN;
            end
        end
    end

    // Write port: popped entries and sweep pixels both land here one cycle after issue.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_en    <= 1'b0;
            r_wr_x     <= '0;
            r_wr_y     <= '0;
            r_wr_color <= '0;
            r_err_oob  <= 1'b0;
        end else begin
            r_wr_en <= 1'b0;
            if (w_pop) begin
                if (w_oob) begin
                    r_err_oob <= 1'b1;
                end else begin
                    r_wr_en    <= 1'b1;
                    r_wr_x     <= w_hx;
                    r_wr_y     <= w_hy;
                    r_wr_color <= w_hc;
                end
            end else if (w_clr_issue) begin
                r_wr_en    <= 1'b1;
                r_wr_x     <= r_cx;
                r_wr_y     <= r_cy;
                r_wr_color <= CLR;
            end
        end
    end

    assign wr_en    = r_wr_en;
    assign wr_x     = r_wr_x;
    assign wr_y     = r_wr_y;
    assign wr_color = r_wr_color;
    assign err_oob  = r_err_oob;
    assign busy     = !w_empty || (r_state == S_CLEAR);

endmodule

// File: tb/tb_paint_write_scheduler.sv
// Directed bench for paint_write_scheduler: blanking gate, backpressure, erase/out-of-range,
// full clear sweep, sweep restart and mid-sweep reset.
module tb_paint_write_scheduler;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [7:0] req_x = '0;
    logic [7:0] req_y = '0;
    logic [2:0] req_color = '0;
    logic       req_brush = 1'b0;
    logic       clear_req = 1'b0;
    logic       blank_b = 1'b1;
    logic       wr_en;
    logic [7:0] wr_x;
    logic [7:0] wr_y;
    logic [2:0] wr_color;
    logic       busy;
    logic       err_oob;

    int n_vec = 0;
    int n_err = 0;

    logic [18:0] wq[$];

    paint_write_scheduler dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_x     (req_x),
        .req_y     (req_y),
        .req_color (req_color),
        .req_brush (req_brush),
        .clear_req (clear_req),
        .blank_b   (blank_b),
        .wr_en     (wr_en),
        .wr_x      (wr_x),
        .wr_y      (wr_y),
        .wr_color  (wr_color),
        .busy      (busy),
        .err_oob   (err_oob)
    );

    always #5 clk = ~clk;

    // Write monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (wr_en) wq.push_back({wr_x, wr_y, wr_color});
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] x, input logic [7:0] y, input logic [2:0] c, input logic b);
        req_valid = 1'b1;
        req_x     = x;
        req_y     = y;
        req_color = c;
        req_brush = b;
        #1;
        n_vec++;
        if (req_ready !== 1'b1) begin
            n_err++;
            $display("FAIL push_ready: req_ready=%b, required 1 for (%0d,%0d)", req_ready, x, y);
        end
        step();
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        #1;
        n_vec++;
        if ({wr_en, wr_x, wr_y, wr_color, busy, err_oob, req_ready} !== {1'b0, 8'd0, 8'd0, 3'd0, 1'b0, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL reset_state: wr_en=%b wr=(%0d,%0d,%0d) busy=%b err_oob=%b req_ready=%b, required 0,(0,0,0),0,0,1",
                     wr_en, wr_x, wr_y, wr_color, busy, err_oob, req_ready);
        end
    endtask

    task automatic test_blanking();
        blank_b = 1'b1;
        wq.delete();
        push(8'd10, 8'd20, 3'd5, 1'b1);
        repeat (8) step();
        n_vec++;
        if (wq.size() != 0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL blank_hold: writes=%0d busy=%b, required 0 writes busy=1", wq.size(), busy);
        end
        blank_b = 1'b0;
        step();
        n_vec++;
        if ({wr_en, wr_x, wr_y, wr_color} !== {1'b1, 8'd10, 8'd20, 3'd5}) begin
            n_err++;
            $display("FAIL blank_release: wr_en=%b (%0d,%0d,%0d), required 1 (10,20,5)", wr_en, wr_x, wr_y, wr_color);
        end
        repeat (3) step();
        n_vec++;
        if (wq.size() != 1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL blank_single: writes=%0d busy=%b, required 1 write busy=0", wq.size(), busy);
        end
    endtask

    task automatic test_backpressure();
        blank_b = 1'b1;
        for (int i = 0; i < 4; i++) push(8'(30 + i), 8'(40 + i), 3'(i + 1), 1'b1);
        #1;
        n_vec++;
        if (req_ready !== 1'b0) begin
            n_err++;
            $display("FAIL full_ready: req_ready=%b, required 0", req_ready);
        end
        req_valid = 1'b1;
        req_x = 8'd99;
        req_y = 8'd99;
        req_color = 3'd7;
        req_brush = 1'b1;
        step();
        req_valid = 1'b0;
        wq.delete();
        blank_b = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            n_vec++;
            if ({wr_en, wr_x, wr_y, wr_color} !== {1'b1, 8'(30 + i), 8'(40 + i), 3'(i + 1)}) begin
                n_err++;
                $display("FAIL drain_%0d: wr_en=%b (%0d,%0d,%0d), required 1 (%0d,%0d,%0d)",
                         i, wr_en, wr_x, wr_y, wr_color, 30 + i, 40 + i, i + 1);
            end
        end
        repeat (3) step();
        n_vec++;
        if (wq.size() != 4 || wr_en !== 1'b0) begin
            n_err++;
            $display("FAIL drain_count: writes=%0d wr_en=%b, required 4 writes wr_en=0", wq.size(), wr_en);
        end
    endtask

    task automatic test_erase_oob();
        blank_b = 1'b0;
        wq.delete();
        push(8'd3, 8'd3, 3'd6, 1'b0);
        repeat (3) step();
        n_vec++;
        if (wq.size() != 1 || (wq.size() == 1 && wq[0] !== {8'd3, 8'd3, 3'd0}) || err_oob !== 1'b0) begin
            n_err++;
            $display("FAIL erase: writes=%0d first=%h err_oob=%b, required 1 write (3,3,0) err_oob=0",
                     wq.size(), (wq.size() > 0) ? wq[0] : 19'h0, err_oob);
        end
        push(8'd160, 8'd0, 3'd1, 1'b1);
        repeat (3) step();
        n_vec++;
        if (wq.size() != 1 || err_oob !== 1'b1) begin
            n_err++;
            $display("FAIL oob_x: writes=%0d err_oob=%b, required 1 write err_oob=1", wq.size(), err_oob);
        end
        push(8'd0, 8'd120, 3'd2, 1'b1);
        push(8'd159, 8'd119, 3'd4, 1'b1);
        repeat (3) step();
        n_vec++;
        if (wq.size() != 2 || (wq.size() == 2 && wq[1] !== {8'd159, 8'd119, 3'd4}) || err_oob !== 1'b1) begin
            n_err++;
            $display("FAIL oob_edge: writes=%0d err_oob=%b, required 2 writes last (159,119,4) err_oob=1",
                     wq.size(), err_oob);
        end
    endtask

    task automatic test_clear();
        int cyc;
        int bad;
        int idx;
        blank_b = 1'b1;
        push(8'd5, 8'd5, 3'd1, 1'b1);
        push(8'd6, 8'd5, 3'd2, 1'b1);
        push(8'd7, 8'd5, 3'd3, 1'b1);
        wq.delete();
        clear_req = 1'b1;
        req_valid = 1'b1;
        req_x = 8'd7;
        req_y = 8'd7;
        req_color = 3'd7;
        req_brush = 1'b1;
        #1;
        n_vec++;
        if (req_ready !== 1'b0) begin
            n_err++;
            $display("FAIL clear_wins: req_ready=%b, required 0", req_ready);
        end
        step();
        clear_req = 1'b0;
        req_valid = 1'b0;
        #1;
        n_vec++;
        if (busy !== 1'b1 || req_ready !== 1'b0) begin
            n_err++;
            $display("FAIL clear_state: busy=%b req_ready=%b, required 1,0", busy, req_ready);
        end
        cyc = 0;
        while (busy === 1'b1 && cyc < 40000) begin
            blank_b = (cyc % 4 == 3);
            step();
            cyc++;
        end
        blank_b = 1'b1;
        n_vec++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL clear_timeout: busy=%b after %0d cycles, required 0", busy, cyc);
        end
        #1;
        n_vec++;
        if (req_ready !== 1'b1) begin
            n_err++;
            $display("FAIL clear_ready: req_ready=%b after sweep, required 1", req_ready);
        end
        repeat (3) step();
        n_vec++;
        if (wq.size() != 19200) begin
            n_err++;
            $display("FAIL clear_count: writes=%0d, required 19200", wq.size());
        end
        bad = 0;
        idx = 0;
        for (int yy = 0; yy < 120; yy++) begin
            for (int xx = 0; xx < 160; xx++) begin
                if (idx >= wq.size() || wq[idx] !== {xx[7:0], yy[7:0], 3'd0}) bad++;
                idx++;
            end
        end
        n_vec++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL clear_order: %0d pixels out of raster order, required 0", bad);
        end
    endtask

    task automatic test_restart_reset();
        int cyc;
        int n0;
        blank_b = 1'b0;
        wq.delete();
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        cyc = 0;
        while (wq.size() < 500 && cyc < 2000) begin
            step();
            cyc++;
        end
        n_vec++;
        if (wq.size() != 500) begin
            n_err++;
            $display("FAIL restart_reach: writes=%0d, required 500", wq.size());
        end
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        n_vec++;
        if (wr_en !== 1'b0) begin
            n_err++;
            $display("FAIL restart_gap: wr_en=%b, required 0", wr_en);
        end
        step();
        n_vec++;
        if ({wr_en, wr_x, wr_y, wr_color} !== {1'b1, 8'd0, 8'd0, 3'd0}) begin
            n_err++;
            $display("FAIL restart_origin: wr_en=%b (%0d,%0d,%0d), required 1 (0,0,0)", wr_en, wr_x, wr_y, wr_color);
        end
        step();
        n_vec++;
        if ({wr_en, wr_x, wr_y} !== {1'b1, 8'd1, 8'd0}) begin
            n_err++;
            $display("FAIL restart_next: wr_en=%b (%0d,%0d), required 1 (1,0)", wr_en, wr_x, wr_y);
        end
        repeat (20) step();
        reset = 1'b1;
        step();
        n_vec++;
        if (wr_en !== 1'b0 || busy !== 1'b0 || wr_x !== 8'd0 || err_oob !== 1'b0) begin
            n_err++;
            $display("FAIL reset_abort: wr_en=%b busy=%b wr_x=%0d err_oob=%b, required 0,0,0,0", wr_en, busy, wr_x, err_oob);
        end
        reset = 1'b0;
        n0 = wq.size();
        repeat (10) step();
        n_vec++;
        if (wq.size() != n0 || busy !== 1'b0 || req_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_quiet: %0d writes after reset busy=%b req_ready=%b, required 0 writes busy=0 req_ready=1",
                     wq.size() - n0, busy, req_ready);
        end
    endtask

    initial begin
        test_reset();
        test_blanking();
        test_backpressure();
        test_erase_oob();
        test_clear();
        test_restart_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
